// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART receiver.
//   - rx_state_t : receiver FSM states
//   - DATA_BITS  : payload bits per frame
//   - bit_clks() : clock cycles per serial bit for a given clock and baud rate
//
// The optional parity bit is controlled by the UART_RX_PARITY_EN macro in
// uart_rx.sv. This package does not depend on that macro.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS = 8;

    // PAR is always part of the encoding. When parity is disabled, the
    // receiver never enters PAR.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4,
        BREAK = 3'd5
    } rx_state_t;

    // Whole clock cycles per bit. The fractional remainder is dropped,
    // so there is a small baud error when freq is not an exact multiple.
    function automatic int bit_clks(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_baud_timer.sv
// ---------------------------------------------------------------------------
// baud_timer
//   Bit-period timer for the UART receiver. It counts 0..BIT_CLKS-1 and
//   wraps. The clear input forces it back to 0, so each state starts
//   timing from a known point.
//
// Parameters
//   BIT_CLKS   clock cycles per serial bit (must be >= 2)
//
// Ports
//   clk        in   1  system clock
//   rst        in   1  asynchronous active-high reset
//   clear      in   1  restart the count at 0 on the next edge
//   half_tick  out  1  counter is at BIT_CLKS/2 - 1 (middle of the start bit)
//   full_tick  out  1  counter is at BIT_CLKS - 1 (one full bit elapsed)
// ---------------------------------------------------------------------------
module baud_timer
    import uart_pkg::*;
#(
    parameter int BIT_CLKS = 5208
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic half_tick,
    output logic full_tick
);

    localparam int HALF = BIT_CLKS / 2;
    localparam int TW   = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;

    localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(BIT_CLKS - 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    // The counter wraps at the end of each bit period. A receiver that
    // stays in one state, such as DATA, then gets a full_tick every
    // BIT_CLKS cycles without reloading anything.
    always_comb begin
        timer_d = timer_q + TW'(1);
        if (clear || (timer_q == FULL_LAST)) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign half_tick = (timer_q == HALF_LAST);
    assign full_tick = (timer_q == FULL_LAST);

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   Asynchronous serial receiver, LSB first.
//   - The line passes through a 2-flop synchronizer.
//   - A start bit is accepted only if the line is still low at mid-bit.
//   - Each data bit is sampled at mid-bit; the stop bit (and optional
//     parity bit) is then checked.
//   - Each received byte is presented with a one-cycle data_strobe.
//
// Configuration
//   UART_RX_PARITY_EN  when defined, the frame is start, 8 data, parity,
//                      stop, and a parity mismatch sets rx_error.
//                      Otherwise the frame is 8N1.
//
// Parameters
//   CLK_FREQUENCY  system clock frequency, Hz
//   BAUD_RATE      serial bit rate, bits/s
//   PARITY         1 = odd, 0 = even (used only when parity is enabled)
//
// Ports
//   clk          in   1  system clock
//   rst          in   1  asynchronous active-high reset
//   rx_in        in   1  serial line, asynchronous, idle high
//   dout         out  8  last received byte
//   data_strobe  out  1  one-cycle pulse when dout/rx_error are updated
//   busy         out  1  a frame (or line break) is in progress
//   rx_error     out  1  last frame had a framing or parity error
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE     = 19_200,
    parameter int PARITY        = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] dout,
    output logic                 data_strobe,
    output logic                 busy,
    output logic                 rx_error
);

    localparam int BIT_CLKS = bit_clks(CLK_FREQUENCY, BAUD_RATE);
    localparam int CW       = $clog2(DATA_BITS);

    localparam logic [CW-1:0] LAST_BIT   = CW'(DATA_BITS - 1);
    localparam logic          PARITY_ODD = (PARITY != 0);

    // -----------------------------------------------------------------------
    // Registers and their next-state values
    // -----------------------------------------------------------------------
    logic [1:0]           sync_q,     sync_d;
    rx_state_t            state_q,    state_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic [CW-1:0]        bit_cnt_q,  bit_cnt_d;
    logic                 perr_q,     perr_d;
    logic [DATA_BITS-1:0] dout_q,     dout_d;
    logic                 strobe_q,   strobe_d;
    logic                 rx_error_q, rx_error_d;

    logic rx_s;
    logic timer_clear;
    logic half_tick;
    logic full_tick;

    // -----------------------------------------------------------------------
    // Synchronizer
    // -----------------------------------------------------------------------

    // Both flops reset high, so the line looks idle coming out of reset.
    // This prevents a false start bit. Every decision below uses only rx_s.
    always_comb begin
        sync_d = {sync_q[0], rx_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rx_s = sync_q[1];

    // -----------------------------------------------------------------------
    // Bit timer
    // -----------------------------------------------------------------------

    // Restart the timer on every state change. START then measures half a
    // bit from the detected edge, and later states measure whole bits from
    // that mid-bit point.
    assign timer_clear = (state_d != state_q);

    baud_timer #(
        .BIT_CLKS (BIT_CLKS)
    ) u_baud_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (timer_clear),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------

    // - A start bit that is high again at mid-bit is treated as a glitch.
    // - A stop bit sampled low means the line may be in a break. BREAK holds
    //   until the line goes high again, so a held-low line cannot start
    //   a new frame.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (half_tick) begin
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (full_tick && (bit_cnt_q == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = PAR;
`else
                    state_d = STOP;
`endif
                end
            end
            PAR: begin
                if (full_tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (full_tick) begin
                    state_d = rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs and datapath next-state logic
    // -----------------------------------------------------------------------

    // Bits shift in at the MSB, so after the last shift the first bit
    // received (the LSB) is in bit 0.
    //
    // perr_q is cleared for every frame. When parity is disabled it stays 0,
    // because PAR is never entered, so rx_error reflects the stop bit only.
    always_comb begin
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        perr_d     = perr_q;
        dout_d     = dout_q;
        strobe_d   = 1'b0;
        rx_error_d = rx_error_q;
        unique case (state_q)
            START: begin
                bit_cnt_d = '0;
                perr_d    = 1'b0;
            end
            DATA: begin
                if (full_tick) begin
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end
            PAR: begin
                if (full_tick) begin
                    perr_d = ((^shift_q) ^ rx_s) != PARITY_ODD;
                end
            end
            STOP: begin
                if (full_tick) begin
                    dout_d     = shift_q;
                    strobe_d   = 1'b1;
                    rx_error_d = perr_q | ~rx_s;
                end
            end
            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------

    // A reset in mid-frame discards the partial byte and sets all outputs
    // back to their reset values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            perr_q     <= 1'b0;
            dout_q     <= '0;
            strobe_q   <= 1'b0;
            rx_error_q <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            perr_q     <= perr_d;
            dout_q     <= dout_d;
            strobe_q   <= strobe_d;
            rx_error_q <= rx_error_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign dout        = dout_q;
    assign data_strobe = strobe_q;
    assign rx_error    = rx_error_q;

endmodule
